note_scheduler: RTL and testbench

- Chart-driven sequencer for the falling-arrow playfield. It replaces per-arrow hard-coded start delays with a single controller.
- Walks an external chart ROM of (spawn frame, lane) entries and allocates each note to a free slot in a fixed pool.
- Advances every active slot's Y position once per frame, judges hits and misses from the keyboard keycodes, and accumulates score, combo and miss counts.
- Slot positions and lanes feed the arrow sprite/colour mapper.

---
 rtl/note_scheduler_if.sv | 13 +
 rtl/note_scheduler.sv | 219 +++++++++++++++++++++
 tb/tb_note_scheduler.sv | 389 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/note_scheduler_if.sv
// Chart ROM bus for note_scheduler: the scheduler drives the address and
// reads back the entry combinationally.
interface note_scheduler_if #(
   parameter int CHART_AW = 6
);
   logic [CHART_AW-1:0] chart_addr;
   logic [11:0]         chart_time;
   logic [1:0]          chart_lane;
   logic                chart_last;

   modport master (output chart_addr, input chart_time, input chart_lane, input chart_last);
   modport slave  (input chart_addr, output chart_time, output chart_lane, output chart_last);
endinterface

// File: rtl/note_scheduler.sv
// Chart-driven falling-note sequencer: spawns notes into a slot pool, moves them,
// judges hits/misses. Define NOTE_SCHED_COMBO_BONUS_EN for the +2 combo bonus.
module note_scheduler #(
   parameter int         NUM_SLOTS = 8,
   parameter int         CHART_AW  = 6,
   parameter int         Y_START   = 100,
   parameter int         Y_MAX     = 400,
   parameter int         ARROW_H   = 40,
   parameter int         HIT_LO    = 340,
   parameter int         SPEED     = 1,
   parameter logic [7:0] KEY_L0    = 8'h04,
   parameter logic [7:0] KEY_L1    = 8'h16,
   parameter logic [7:0] KEY_L2    = 8'h07,
   parameter logic [7:0] KEY_L3    = 8'h09,
   parameter logic [7:0] START_KEY = 8'h2C,
   parameter logic [7:0] RESET_KEY = 8'h01
) (
   input  logic                   frame_clk,
   input  logic                   Reset,
   input  logic [7:0]             keycode,
   input  logic [7:0]             keycode_second,
   note_scheduler_if.master       chart,
   output logic [NUM_SLOTS-1:0]   slot_active,
   output logic [2*NUM_SLOTS-1:0] slot_lane,
   output logic [10*NUM_SLOTS-1:0] slot_y,
   output logic [11:0]            score,
   output logic [7:0]             miss_cnt,
   output logic [7:0]             combo,
   output logic                   playing,
   output logic                   done
);

   localparam logic [1:0] ST_HALTED  = 2'd0;
   localparam logic [1:0] ST_PLAYING = 2'd1;
   localparam logic [1:0] ST_END     = 2'd2;

   logic [1:0]           state;
   logic [11:0]          frame_cnt;
   logic [CHART_AW-1:0]  chart_addr;
   logic                 exhausted;
   logic [3:0]           prev_press;
   logic [3:0]           press_now;
   logic [3:0]           press_evt;
   logic [1:0]           lane_q [NUM_SLOTS];
   logic [9:0]           y_q    [NUM_SLOTS];
   logic [10:0]          y_ext  [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] miss_vec;
   logic [NUM_SLOTS-1:0] hit_vec;
   logic [NUM_SLOTS-1:0] spawn_vec;
   logic [NUM_SLOTS-1:0] best_oh;
   logic [9:0]           best_y;
   logic                 best_found;
   logic                 free_found;
   logic                 spawn_due;
   logic                 drop;
   logic [3:0]           hit_count;
   logic [7:0]           miss_count;
   logic [7:0]           miss_total;
   logic [12:0]          hit_inc;
   logic [12:0]          score_sum;
   logic [8:0]           miss_sum;
   logic [8:0]           combo_sum;
   logic [7:0]           combo_base;

   assign chart.chart_addr = chart_addr;
   assign playing          = (state == ST_PLAYING);
   assign done             = (state == ST_END);

   always_comb begin
      slot_lane = '0;
      slot_y    = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         slot_lane[2*i +: 2]  = lane_q[i];
         slot_y[10*i +: 10]   = y_q[i];
      end
   end

   // A lane fires only on the frame its key first appears on either keycode input.
   always_comb begin
      press_now[0] = (keycode == KEY_L0) || (keycode_second == KEY_L0);
      press_now[1] = (keycode == KEY_L1) || (keycode_second == KEY_L1);
      press_now[2] = (keycode == KEY_L2) || (keycode_second == KEY_L2);
      press_now[3] = (keycode == KEY_L3) || (keycode_second == KEY_L3);
      press_evt    = press_now & ~prev_press;
   end

   // Judge every slot on its pre-motion Y; sums are 11 bits so they never wrap.
   always_comb begin
      miss_vec   = '0;
      hit_vec    = '0;
      spawn_vec  = '0;
      best_oh    = '0;
      best_y     = '0;
      best_found = 1'b0;
      free_found = 1'b0;
      hit_count  = '0;
      miss_count = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         y_ext[i]    = {1'b0, y_q[i]} + 11'(ARROW_H);
         miss_vec[i] = slot_active[i] && (y_ext[i] >= 11'(Y_MAX));
      end
      for (int l = 0; l < 4; l++) begin
         best_oh    = '0;
         best_y     = '0;
         best_found = 1'b0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            if (press_evt[l] && slot_active[i] && (lane_q[i] == 2'(l)) &&
                (y_ext[i] >= 11'(HIT_LO)) && (y_ext[i] < 11'(Y_MAX)) &&
                (!best_found || (y_q[i] > best_y))) begin
               best_found = 1'b1;
               best_y     = y_q[i];
               best_oh    = '0;
               best_oh[i] = 1'b1;
            end
         end
         hit_vec = hit_vec | best_oh;
      end
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (!free_found && !slot_active[i]) begin
            free_found   = 1'b1;
            spawn_vec[i] = 1'b1;
         end
         hit_count  = hit_count + 4'(hit_vec[i]);
         miss_count = miss_count + 8'(miss_vec[i]);
      end
   end

   // Counter arithmetic: a miss on the same edge as a hit clears combo before the hits add.
   always_comb begin
      spawn_due  = !exhausted && (chart.chart_time <= frame_cnt);
      drop       = spawn_due && !free_found;
      miss_total = miss_count + 8'(drop);
      hit_inc    = 13'(hit_count);
`ifdef NOTE_SCHED_COMBO_BONUS_EN
      if (combo >= 8'd10) begin
         hit_inc = 13'(hit_count) << 1;
      end
`else
`endif
      score_sum  = {1'b0, score} + hit_inc;
      miss_sum   = {1'b0, miss_cnt} + {1'b0, miss_total};
      combo_base = (miss_total != 8'd0) ? 8'd0 : combo;
      combo_sum  = {1'b0, combo_base} + 9'(hit_count);
   end

   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         state       <= ST_HALTED;
         frame_cnt   <= '0;
         chart_addr  <= '0;
         exhausted   <= 1'b0;
         prev_press  <= '0;
         slot_active <= '0;
         score       <= '0;
         miss_cnt    <= '0;
         combo       <= '0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            lane_q[i] <= '0;
            y_q[i]    <= '0;
         end
      end else begin
         prev_press <= press_now;
         case (state)
            ST_HALTED: begin
               if (keycode == START_KEY) begin
                  state       <= ST_PLAYING;
                  frame_cnt   <= '0;
                  chart_addr  <= '0;
                  exhausted   <= 1'b0;
                  slot_active <= '0;
                  score       <= '0;
                  miss_cnt    <= '0;
                  combo       <= '0;
                  for (int i = 0; i < NUM_SLOTS; i++) begin
                     lane_q[i] <= '0;
                     y_q[i]    <= '0;
                  end
               end
            end
            ST_PLAYING: begin
               if (exhausted && (slot_active == '0)) begin
                  state <= ST_END;
               end
               if (frame_cnt != 12'hFFF) begin
                  frame_cnt <= frame_cnt + 12'd1;
               end
               // Spawn targets a slot free before this edge; freed slots wait a frame.
               for (int i = 0; i < NUM_SLOTS; i++) begin
                  if (spawn_due && spawn_vec[i]) begin
                     slot_active[i] <= 1'b1;
                     lane_q[i]      <= chart.chart_lane;
                     y_q[i]         <= 10'(Y_START);
                  end else if (miss_vec[i] || hit_vec[i]) begin
                     slot_active[i] <= 1'b0;
                  end else if (slot_active[i]) begin
                     y_q[i] <= y_q[i] + 10'(SPEED);
                  end
               end
               if (spawn_due) begin
                  chart_addr <= chart_addr + 1'b1;
                  if (chart.chart_last) begin
                     exhausted <= 1'b1;
                  end
               end
               score    <= (score_sum > 13'd4095) ? 12'd4095 : score_sum[11:0];
               miss_cnt <= (miss_sum > 9'd255) ? 8'd255 : miss_sum[7:0];
               combo    <= (combo_sum > 9'd255) ? 8'd255 : combo_sum[7:0];
            end
            ST_END: begin
               if (keycode == RESET_KEY) begin
                  state <= ST_HALTED;
               end
            end
            default: state <= ST_HALTED;
         endcase
      end
   end

endmodule

// File: tb/tb_note_scheduler.sv
// Scoreboard bench for note_scheduler: a frame-level behavioural model predicts every
// post-edge output set; a monitor pops and compares one prediction per frame.
module tb_note_scheduler;

   typedef struct packed {
      logic [7:0]  active;
      logic [15:0] lanes;
      logic [79:0] ys;
      logic [11:0] score;
      logic [7:0]  miss;
      logic [7:0]  combo;
      logic        playing;
      logic        done;
      logic [5:0]  addr;
   } exp_t;

   logic        frame_clk;
   logic        Reset;
   logic [7:0]  keycode;
   logic [7:0]  keycode_second;
   logic [7:0]  slot_active;
   logic [15:0] slot_lane;
   logic [79:0] slot_y;
   logic [11:0] score;
   logic [7:0]  miss_cnt;
   logic [7:0]  combo;
   logic        playing;
   logic        done;

   logic [11:0] ch_time [64];
   logic [1:0]  ch_lane [64];
   logic        ch_last [64];

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Behavioural model state (0 halted, 1 playing, 2 end)
   int   m_state, m_fcnt, m_addr, m_score, m_miss, m_combo;
   bit   m_exh;
   int   m_act [8];
   int   m_y   [8];
   int   m_lane[8];
   bit   m_prev[4];
   int   lane_key[4] = '{8'h04, 8'h16, 8'h07, 8'h09};

   note_scheduler_if #(.CHART_AW(6)) cif ();

   assign cif.chart_time = ch_time[cif.chart_addr];
   assign cif.chart_lane = ch_lane[cif.chart_addr];
   assign cif.chart_last = ch_last[cif.chart_addr];

   note_scheduler dut (
      .frame_clk      (frame_clk),
      .Reset          (Reset),
      .keycode        (keycode),
      .keycode_second (keycode_second),
      .chart          (cif),
      .slot_active    (slot_active),
      .slot_lane      (slot_lane),
      .slot_y         (slot_y),
      .score          (score),
      .miss_cnt       (miss_cnt),
      .combo          (combo),
      .playing        (playing),
      .done           (done)
   );

   initial frame_clk = 1'b0;
   always #5 frame_clk = ~frame_clk;

   task automatic checkOutput(input string name, input logic [79:0] got, input logic [79:0] want);
      n_checks++;
      if (got !== want) begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
      end else begin
         n_pass++;
      end
   endtask

   task automatic clearModel();
      m_fcnt = 0; m_addr = 0; m_score = 0; m_miss = 0; m_combo = 0; m_exh = 0;
      for (int i = 0; i < 8; i++) begin
         m_act[i] = 0; m_y[i] = 0; m_lane[i] = 0;
      end
   endtask

   // One frame of the game rules, applied to the model's pre-edge state.
   task automatic modelStep(input bit rst, input logic [7:0] k1, input logic [7:0] k2);
      bit ev[4];
      int freed[8];
      int nmiss, nhit, best, sp, inc, key;
      bit exh_before, was_empty;
      if (rst) begin
         m_state = 0;
         clearModel();
         for (int l = 0; l < 4; l++) m_prev[l] = 0;
         return;
      end
      for (int l = 0; l < 4; l++) begin
         key   = lane_key[l];
         ev[l] = ((int'(k1) == key) || (int'(k2) == key)) && !m_prev[l];
         m_prev[l] = (int'(k1) == key) || (int'(k2) == key);
      end
      if (m_state == 0) begin
         if (k1 == 8'h2C) begin
            m_state = 1;
            clearModel();
         end
      end else if (m_state == 2) begin
         if (k1 == 8'h01) m_state = 0;
      end else begin
         exh_before = m_exh;
         was_empty  = 1;
         nmiss = 0; nhit = 0; sp = -1;
         for (int i = 0; i < 8; i++) begin
            freed[i] = 0;
            if (m_act[i] != 0) was_empty = 0;
            if (m_act[i] != 0 && m_y[i] + 40 >= 400) begin
               freed[i] = 1;
               nmiss++;
            end
         end
         for (int l = 0; l < 4; l++) begin
            if (ev[l]) begin
               best = -1;
               for (int i = 0; i < 8; i++) begin
                  if (m_act[i] != 0 && m_lane[i] == l && m_y[i] + 40 >= 340 && m_y[i] + 40 < 400)
                     if (best < 0 || m_y[i] > m_y[best]) best = i;
               end
               if (best >= 0) begin
                  freed[best] = 1;
                  nhit++;
               end
            end
         end
         if (!m_exh && int'(ch_time[m_addr]) <= m_fcnt) begin
            for (int i = 7; i >= 0; i--) if (m_act[i] == 0) sp = i;
            if (sp < 0) nmiss++;
            if (ch_last[m_addr]) m_exh = 1;
         end
         inc = nhit;
`ifdef NOTE_SCHED_COMBO_BONUS_EN
         if (m_combo >= 10) inc = 2 * nhit;
`endif
         m_score = (m_score + inc > 4095) ? 4095 : m_score + inc;
         m_miss  = (m_miss + nmiss > 255) ? 255 : m_miss + nmiss;
         m_combo = (nmiss > 0) ? nhit : m_combo + nhit;
         if (m_combo > 255) m_combo = 255;
         for (int i = 0; i < 8; i++) begin
            if (freed[i] != 0) m_act[i] = 0;
            else if (m_act[i] != 0) m_y[i] = m_y[i] + 1;
         end
         if (sp >= 0) begin
            m_act[sp] = 1; m_y[sp] = 100; m_lane[sp] = int'(ch_lane[m_addr]);
         end
         if (!m_exh || exh_before || int'(ch_time[m_addr]) <= m_fcnt)
            if (int'(ch_time[m_addr]) <= m_fcnt && !exh_before) m_addr = (m_addr + 1) % 64;
         m_fcnt = (m_fcnt >= 4095) ? 4095 : m_fcnt + 1;
         if (exh_before && was_empty) m_state = 2;
      end
   endtask

   function automatic exp_t buildExp();
      exp_t e;
      e = '0;
      for (int i = 0; i < 8; i++) begin
         e.active[i]       = (m_act[i] != 0);
         e.lanes[2*i +: 2] = 2'(m_lane[i]);
         e.ys[10*i +: 10]  = 10'(m_y[i]);
      end
      e.score   = 12'(m_score);
      e.miss    = 8'(m_miss);
      e.combo   = 8'(m_combo);
      e.playing = (m_state == 1);
      e.done    = (m_state == 2);
      e.addr    = 6'(m_addr);
      return e;
   endfunction

   // Drive one frame, predict its outcome, return 2 time units after the edge.
   task automatic applyStimulus(input logic r, input logic [7:0] a, input logic [7:0] b);
      Reset = r; keycode = a; keycode_second = b;
      modelStep(r, a, b);
      sb.push_back(buildExp());
      @(posedge frame_clk);
      #2;
   endtask

   task automatic clearChart();
      for (int i = 0; i < 64; i++) begin
         ch_time[i] = 12'hFFF; ch_lane[i] = 2'd0; ch_last[i] = 1'b1;
      end
   endtask

   task automatic setEntry(input int idx, input int t, input int lane, input bit last);
      ch_time[idx] = 12'(t); ch_lane[idx] = 2'(lane); ch_last[idx] = last;
   endtask

   task automatic resetAndStart();
      applyStimulus(1'b1, 8'h00, 8'h00);
      applyStimulus(1'b0, 8'h2C, 8'h00);
   endtask

   task automatic idleUntilEnd(input string tag, input int cap);
      int n = 0;
      while (m_state != 2 && n < cap) begin
         applyStimulus(1'b0, 8'h00, 8'h00);
         n++;
      end
      if (m_state != 2) begin
         n_checks++;
         $display("[TB] FAIL %s_timeout: got %0d frames, expected end before %0d", tag, n, cap);
      end
   endtask

   function automatic logic [7:0] pickKey();
      case ($urandom_range(0, 5))
         0: return 8'h00;
         1: return 8'h04;
         2: return 8'h16;
         3: return 8'h07;
         4: return 8'h09;
         default: return 8'($urandom_range(0, 255));
      endcase
   endfunction

   // Monitor: one prediction per edge, compared 1 time unit after that edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge frame_clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("slot_active", 80'(slot_active), 80'(e.active));
            checkOutput("slot_lane",   80'(slot_lane),   80'(e.lanes));
            checkOutput("slot_y",      slot_y,           e.ys);
            checkOutput("score",       80'(score),       80'(e.score));
            checkOutput("miss_cnt",    80'(miss_cnt),    80'(e.miss));
            checkOutput("combo",       80'(combo),       80'(e.combo));
            checkOutput("playing",     80'(playing),     80'(e.playing));
            checkOutput("done",        80'(done),        80'(e.done));
            checkOutput("chart_addr",  80'(cif.chart_addr), 80'(e.addr));
         end
      end
   end

   initial begin
      int n;
      bit held;
      logic [7:0] k1, k2, kp;
      Reset = 1'b1; keycode = 8'h00; keycode_second = 8'h00;
      m_state = 0;
      clearModel();
      for (int l = 0; l < 4; l++) m_prev[l] = 0;
      clearChart();
      @(posedge frame_clk);
      #2;

      $display("[TB] single note, no press: missed then done");
      clearChart(); setEntry(0, 5, 2, 1);
      applyStimulus(1'b1, 8'h00, 8'h00);
      checkOutput("rst_active", 80'(slot_active), 80'd0);
      checkOutput("rst_y",      slot_y,           80'd0);
      checkOutput("rst_score",  80'(score),       80'd0);
      checkOutput("rst_state",  80'({playing, done}), 80'd0);
      applyStimulus(1'b0, 8'h2C, 8'h00);
      idleUntilEnd("t1", 600);
      checkOutput("t1_miss",  80'(miss_cnt), 80'd1);
      checkOutput("t1_combo", 80'(combo),    80'd0);
      checkOutput("t1_done",  80'(done),     80'd1);
      applyStimulus(1'b0, 8'h01, 8'h00);
      checkOutput("t1_halted", 80'({playing, done}), 80'd0);

      $display("[TB] second keycode hit at Y=330, held key for later note");
      clearChart(); setEntry(0, 5, 2, 0); setEntry(1, 40, 2, 1);
      resetAndStart();
      held = 0; n = 0;
      while (m_state != 2 && n < 800) begin
         if (m_act[0] != 0 && m_y[0] == 330) held = 1;
         applyStimulus(1'b0, 8'h00, held ? 8'h07 : 8'h00);
         n++;
      end
      checkOutput("t2_score", 80'(score),    80'd1);
      checkOutput("t2_miss",  80'(miss_cnt), 80'd1);
      checkOutput("t2_done",  80'(done),     80'd1);

      $display("[TB] press outside window");
      clearChart(); setEntry(0, 5, 2, 1);
      resetAndStart();
      n = 0;
      while (!(m_act[0] != 0 && m_y[0] == 250) && n < 400) begin
         applyStimulus(1'b0, 8'h00, 8'h00);
         n++;
      end
      applyStimulus(1'b0, 8'h07, 8'h00);
      checkOutput("t3_active", 80'(slot_active), 80'd1);
      checkOutput("t3_score",  80'(score),       80'd0);
      idleUntilEnd("t3", 600);

      $display("[TB] nine simultaneous entries");
      clearChart();
      for (int i = 0; i < 9; i++) setEntry(i, 0, i % 4, i == 8);
      resetAndStart();
      repeat (9) applyStimulus(1'b0, 8'h00, 8'h00);
      checkOutput("t4_full", 80'(slot_active), 80'hFF);
      checkOutput("t4_miss", 80'(miss_cnt),    80'd1);
      idleUntilEnd("t4", 600);

      $display("[TB] two lane-0 notes, larger Y wins");
      clearChart(); setEntry(0, 0, 0, 0); setEntry(1, 20, 0, 1);
      resetAndStart();
      n = 0;
      while (!(m_act[0] != 0 && m_y[0] == 320) && n < 400) begin
         applyStimulus(1'b0, 8'h00, 8'h00);
         n++;
      end
      applyStimulus(1'b0, 8'h04, 8'h00);
      checkOutput("t5_active", 80'(slot_active), 80'h02);
      checkOutput("t5_score",  80'(score),       80'd1);
      idleUntilEnd("t5", 600);

      $display("[TB] reset mid-play");
      clearChart();
      for (int i = 0; i < 5; i++) setEntry(i, 0, 1, i == 4);
      resetAndStart();
      repeat (3) applyStimulus(1'b0, 8'h00, 8'h00);
      applyStimulus(1'b1, 8'h00, 8'h00);
      checkOutput("t6_active", 80'(slot_active), 80'd0);
      checkOutput("t6_lane",   80'(slot_lane),   80'd0);
      checkOutput("t6_y",      slot_y,           80'd0);
      checkOutput("t6_addr",   80'(cif.chart_addr), 80'd0);
      checkOutput("t6_state",  80'({playing, done}), 80'd0);

      $display("[TB] eleven consecutive hits");
      clearChart();
      for (int i = 0; i < 11; i++) setEntry(i, 30 * i, 0, i == 10);
      resetAndStart();
      n = 0;
      while (m_state != 2 && n < 1200) begin
         kp = 8'h00;
         for (int i = 0; i < 8; i++)
            if (m_act[i] != 0 && m_lane[i] == 0 && m_y[i] == 330) kp = 8'h04;
         applyStimulus(1'b0, kp, 8'h00);
         n++;
      end
`ifdef NOTE_SCHED_COMBO_BONUS_EN
      checkOutput("t7_score", 80'(score), 80'd12);
`else
      checkOutput("t7_score", 80'(score), 80'd11);
`endif
      checkOutput("t7_combo", 80'(combo),    80'd11);
      checkOutput("t7_miss",  80'(miss_cnt), 80'd0);

      $display("[TB] randomized charts and keys");
      for (int run = 0; run < 3; run++) begin
         clearChart();
         n = 0;
         for (int i = 0; i < 30; i++) begin
            n = n + int'($urandom_range(0, 12));
            setEntry(i, n, int'($urandom_range(0, 3)), i == 29);
         end
         resetAndStart();
         k1 = 8'h00; k2 = 8'h00;
         n = 0;
         while (m_state != 2 && n < 2500) begin
            if ($urandom_range(0, 2) == 0) k1 = pickKey();
            if ($urandom_range(0, 2) == 0) k2 = pickKey();
            if (m_state == 0) applyStimulus(1'b0, 8'h2C, k2);
            else if ($urandom_range(0, 799) == 0) applyStimulus(1'b1, k1, k2);
            else applyStimulus(1'b0, k1, k2);
            n++;
         end
         applyStimulus(1'b0, 8'h01, 8'h00);
      end

      repeat (2) applyStimulus(1'b0, 8'h00, 8'h00);
      @(posedge frame_clk);
      #3;
      if (sb.size() != 0) begin
         n_checks++;
         $display("[TB] FAIL sb_drain: got %0d pending, expected 0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
